// File: rtl/spi_wb_sequencer.sv
// SPI-byte to Wishbone B4 sequencer: CMD/ADR/WDAT bytes drive one single Wishbone cycle per command.
// Optional bus watchdog under `WB_TIMEOUT_EN` (TIMEOUT cycles, ERR_BYTE reply, reads return zeros).
module spi_wb_sequencer #(
`ifdef WB_TIMEOUT_EN
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE,
`endif
    parameter logic [7:0]  STALL_BYTE = 8'h00,
    parameter logic [7:0]  ACK_BYTE   = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_data_i,
    input  logic        frame_rst_i,
    output logic        tx_stb_o,
    output logic [7:0]  tx_data_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {
        S_CMD,
        S_ADR,
        S_WDAT,
        S_BUSY,
        S_RDAT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        tx_stb_q, tx_stb_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ack_now;

`ifdef WB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic            err_q, err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_CMD;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdat_q    <= '0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= '0;
`ifdef WB_TIMEOUT_EN
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdat_q    <= rdat_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
`ifdef WB_TIMEOUT_EN
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdat_d    = rdat_q;
        tx_stb_d  = 1'b0;
        tx_data_d = tx_data_q;
        ack_now   = cyc_q & wb_ack_i;
`ifdef WB_TIMEOUT_EN
        err_d     = err_q;
        to_cnt_d  = to_cnt_q;
`endif

        // Bus side runs independently of byte traffic; an ack ends the cycle outright.
        if (stb_q && !wb_stall_i)
            stb_d = 1'b0;
        if (ack_now) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            ack_d = 1'b1;
            if (!we_q)
                rdat_d = wb_dat_i;
        end
`ifdef WB_TIMEOUT_EN
        else if (cyc_q) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                cyc_d  = 1'b0;
                stb_d  = 1'b0;
                err_d  = 1'b1;
                rdat_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif

        if (rx_stb_i) begin
            tx_stb_d  = 1'b1;
            tx_data_d = STALL_BYTE;
            case (state_q)
                S_CMD: begin
                    we_d    = rx_data_i[7];
                    sel_d   = rx_data_i[3:0];
                    state_d = S_ADR;
                end
                S_ADR: begin
                    adr_d = rx_data_i;
                    if (we_q) begin
                        cnt_d   = '0;
                        state_d = S_WDAT;
                    end else begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = S_BUSY;
`ifdef WB_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
                S_WDAT: begin
                    dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = S_BUSY;
`ifdef WB_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
                S_BUSY: begin
`ifdef WB_TIMEOUT_EN
                    if (err_q) begin
                        tx_data_d = ERR_BYTE;
                        err_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = we_q ? S_CMD : S_RDAT;
                    end else
`endif
                    if (ack_q || ack_now) begin
                        tx_data_d = ACK_BYTE;
                        ack_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = we_q ? S_CMD : S_RDAT;
                    end
                end
                S_RDAT: begin
                    tx_data_d = rdat_q[31:24];
                    rdat_d    = {rdat_q[23:0], 8'h00};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_CMD;
                end
                default: state_d = S_CMD;
            endcase
        end

        // Chip-select deassert wins over everything, including a byte in the same cycle.
        if (frame_rst_i) begin
            state_d  = S_CMD;
            cnt_d    = '0;
            ack_d    = 1'b0;
            cyc_d    = 1'b0;
            stb_d    = 1'b0;
            tx_stb_d = 1'b0;
`ifdef WB_TIMEOUT_EN
            err_d    = 1'b0;
`endif
        end
    end

    assign tx_stb_o  = tx_stb_q;
    assign tx_data_o = tx_data_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Directed bench for spi_wb_sequencer (default build): write, read, ack timing, frame abort, reset.
module tb_spi_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        frame_rst = 1'b0;
    logic        tx_stb;
    logic [7:0]  tx_data;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int issued  = 0;

    spi_wb_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .rx_stb_i(rx_stb), .rx_data_i(rx_data), .frame_rst_i(frame_rst),
        .tx_stb_o(tx_stb), .tx_data_o(tx_data),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_sel_o(wb_sel), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall), .wb_ack_i(wb_ack)
    );

    always #5 clk = ~clk;

    // Count STB acceptances (stall-free STB) as issued bus cycles.
    always @(negedge clk)
        if (!rst && wb_cyc && wb_stb && !wb_stall) issued++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic [7:0] exp);
        rx_stb  = 1'b1;
        rx_data = b;
        tick();
        rx_stb  = 1'b0;
        chk(tag, {23'h0, tx_stb, tx_data}, {23'h0, 1'b1, exp});
    endtask

    task automatic send_quiet(input logic [7:0] b);
        send("stall_reply", b, 8'h00);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ctl", {28'h0, tx_stb, wb_cyc, wb_stb, wb_we}, 32'h0);
        chk("rst_sel_adr", {20'h0, wb_sel, wb_adr}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_tx", {24'h0, tx_data}, 32'h0);
        rst = 1'b0;

        // Write 0xDEADBEEF to 0x10, ack 3 cycles after STB acceptance.
        send("w_cmd", 8'h8F, 8'h00);
        tick();
        chk("tx_stb_pulse", {31'h0, tx_stb}, 32'h0);
        send("w_adr", 8'h10, 8'h00);
        send("w_d0", 8'hDE, 8'h00);
        send("w_d1", 8'hAD, 8'h00);
        send("w_d2", 8'hBE, 8'h00);
        send("w_d3", 8'hEF, 8'h00);
        chk("w_cycstb", {30'h0, wb_cyc, wb_stb}, 32'h3);
        chk("w_we_sel_adr", {19'h0, wb_we, wb_sel, wb_adr}, {19'h0, 1'b1, 4'hF, 8'h10});
        chk("w_dat", wb_dat_o, 32'hDEADBEEF);
        tick();
        chk("w_stb_drop", {30'h0, wb_cyc, wb_stb}, 32'h2);
        send("w_busy", 8'h55, 8'h00);
        tick();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("w_cyc_drop", {31'h0, wb_cyc}, 32'h0);
        send("w_ack_reply", 8'h00, 8'hFF);
        chk("w_issued", issued, 1);

        // Read from 0x20 with two stalled cycles.
        send("r_cmd", 8'h03, 8'h00);
        send("r_adr", 8'h20, 8'h00);
        wb_stall = 1'b1;
        chk("r_cycstb", {30'h0, wb_cyc, wb_stb}, 32'h3);
        chk("r_we_sel_adr", {19'h0, wb_we, wb_sel, wb_adr}, {19'h0, 1'b0, 4'h3, 8'h20});
        tick();
        chk("r_stall1", {31'h0, wb_stb}, 32'h1);
        tick();
        chk("r_stall2", {31'h0, wb_stb}, 32'h1);
        wb_stall = 1'b0;
        tick();
        chk("r_accept", {30'h0, wb_cyc, wb_stb}, 32'h2);
        send("r_busy", 8'hA5, 8'h00);
        wb_ack   = 1'b1;
        wb_dat_i = 32'h12345678;
        tick();
        wb_ack   = 1'b0;
        wb_dat_i = 32'hDEADDEAD;
        chk("r_cyc_drop", {31'h0, wb_cyc}, 32'h0);
        send("r_ack_reply", 8'h00, 8'hFF);
        send("r_b0", 8'h00, 8'h12);
        send("r_b1", 8'h00, 8'h34);
        send("r_b2", 8'h00, 8'h56);
        send("r_b3", 8'h00, 8'h78);

        // Back-to-back write; ack arrives with the rx byte in BUSY.
        send("c_cmd", 8'h80, 8'h00);
        send_quiet(8'h44);
        send_quiet(8'h01);
        send_quiet(8'h02);
        send_quiet(8'h03);
        send_quiet(8'h04);
        chk("c_cycstb", {30'h0, wb_cyc, wb_stb}, 32'h3);
        tick();
        wb_ack = 1'b1;
        send("c_ack_same", 8'h99, 8'hFF);
        wb_ack = 1'b0;
        chk("c_cyc_drop", {31'h0, wb_cyc}, 32'h0);
        chk("c_dat", wb_dat_o, 32'h01020304);
        chk("c_sel_adr", {20'h0, wb_sel, wb_adr}, {20'h0, 4'h0, 8'h44});
        chk("c_issued", issued, 3);

        // Frame abort mid write-data.
        send_quiet(8'h81);
        send_quiet(8'h30);
        send_quiet(8'hAA);
        send_quiet(8'hBB);
        frame_rst = 1'b1;
        tick();
        frame_rst = 1'b0;
        chk("f_no_cyc", {31'h0, wb_cyc}, 32'h0);
        rx_stb    = 1'b1;
        rx_data   = 8'hCC;
        frame_rst = 1'b1;
        tick();
        rx_stb    = 1'b0;
        frame_rst = 1'b0;
        chk("f_drop_byte", {31'h0, tx_stb}, 32'h0);
        send_quiet(8'h01);
        send_quiet(8'h50);
        chk("f_cmd_state", {30'h0, wb_cyc, wb_stb}, 32'h3);
        chk("f_adr", {24'h0, wb_adr}, 32'h50);
        chk("f_issued", issued, 3);
        tick();
        frame_rst = 1'b1;
        tick();
        frame_rst = 1'b0;
        chk("f_abort", {30'h0, wb_cyc, wb_stb}, 32'h0);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        send_quiet(8'h02);
        send_quiet(8'h60);
        send("f_late_ack", 8'h77, 8'h00);
        frame_rst = 1'b1;
        tick();
        frame_rst = 1'b0;

        // Reset with a stalled cycle in flight, then a fresh write.
        wb_stall = 1'b1;
        send_quiet(8'h02);
        send_quiet(8'h61);
        tick();
        chk("x_pre", {30'h0, wb_cyc, wb_stb}, 32'h3);
        rst = 1'b1;
        tick();
        chk("x_ctl", {28'h0, tx_stb, wb_cyc, wb_stb, wb_we}, 32'h0);
        chk("x_sel_adr", {20'h0, wb_sel, wb_adr}, 32'h0);
        chk("x_dat_tx", {wb_dat_o[23:0], tx_data}, 32'h0);
        rst = 1'b0;
        wb_stall = 1'b0;
        send_quiet(8'h8A);
        send_quiet(8'h77);
        send_quiet(8'h11);
        send_quiet(8'h22);
        send_quiet(8'h33);
        send_quiet(8'h44);
        chk("n_dat", wb_dat_o, 32'h11223344);
        chk("n_we_sel_adr", {19'h0, wb_we, wb_sel, wb_adr}, {19'h0, 1'b1, 4'hA, 8'h77});
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("n_ack_at_accept", {30'h0, wb_cyc, wb_stb}, 32'h0);
        send("n_ack_reply", 8'h00, 8'hFF);
        chk("n_issued", issued, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_wb_sequencer.md
Name: spi_wb_sequencer

Overview:
- Protocol sequencer between the SPI byte link (already crossed into the Wishbone clock domain) and the Wishbone B4 controller port.
- Decodes command/address/data bytes from the SPI host and runs one single Wishbone cycle per command.
- Produces one reply byte per received byte: stall/ack status, then read data.
- Sits between the clock-domain import/export blocks and the Wishbone bus.

Parameters:
- TIMEOUT, 255: clock cycles to wait for wb_ack before aborting. Used only with WB_TIMEOUT_EN.
- STALL_BYTE, 8'h00: reply while the cycle is pending.
- ACK_BYTE, 8'hFF: reply once the cycle is acknowledged.
- ERR_BYTE, 8'hEE: reply on timeout. Used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  Wishbone clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_stb  in  1  one-cycle pulse: rx_data holds a new SPI byte.
- rx_data  in  8  received byte.
- frame_rst  in  1  one-cycle pulse on chip-select deassert; ends the frame.
- tx_stb  out  1  one-cycle pulse: tx_data is the byte for the next SPI slot.
- tx_data  out  8  reply byte.
- wb_cyc  out  1  Wishbone CYC.
- wb_stb  out  1  Wishbone STB.
- wb_we  out  1  Wishbone WE.
- wb_sel  out  4  Wishbone SEL.
- wb_adr  out  8  Wishbone ADR.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_stall  in  1  Wishbone STALL.
- wb_ack  in  1  Wishbone ACK.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=CMD; wb_cyc, wb_stb, wb_we, tx_stb = 0; wb_sel, wb_adr, wb_dat_o, tx_data = 0; byte counter=0; ack flag=0.
- Reply timing: every accepted rx_stb produces exactly one tx_stb on the next clock (1-cycle latency), carrying the reply for the following byte slot.
  - Reply in CMD, ADR and WDAT: STALL_BYTE.
- State CMD: on rx_stb latch wb_we=rx_data[7] and wb_sel=rx_data[3:0]; bits 6:4 are ignored. Go to ADR.
- State ADR: on rx_stb latch wb_adr.
  - Read: next cycle wb_cyc=wb_stb=1; go to BUSY.
  - Write: clear counter; go to WDAT.
- State WDAT: 4 bytes, MSB first, shifted into wb_dat_o. On the 4th byte, next cycle wb_cyc=wb_stb=1 with wb_we=1; go to BUSY.
- State BUSY:
  - wb_stb stays high until a cycle with wb_stb=1 and wb_stall=0; it deasserts the following cycle.
  - wb_cyc stays high until wb_ack is seen, and drops the cycle after wb_ack.
  - On wb_ack, set the ack flag; for reads, capture wb_dat_i.
  - wb_ack is honoured only while wb_cyc=1. An ack arriving in the same cycle as the stall-free STB is legal.
  - Each rx_stb with ack flag=0 replies STALL_BYTE and stays in BUSY.
  - Each rx_stb with ack flag=1 replies ACK_BYTE, clears the flag, and goes to RDAT (read) or CMD (write).
  - wb_ack and rx_stb in the same cycle: the ack counts, so the reply is ACK_BYTE.
- State RDAT: each rx_stb replies the next captured data byte, MSB first (31:24 first). After the 4th byte go to CMD.
- Ignored input: contents of rx bytes received in BUSY and RDAT.
- frame_rst (any state):
  - Next cycle state=CMD; counter and ack flag cleared; no tx_stb for a byte arriving that same cycle.
  - If wb_cyc=1, wb_cyc and wb_stb drop next cycle (abort); a late wb_ack is ignored.
  - frame_rst and rx_stb in the same cycle: frame_rst wins and the byte is discarded.
- rst mid-cycle: all outputs return to reset values next cycle regardless of bus state.
- Multiple SPI frames are independent; back-to-back commands within one frame are allowed, since a return to CMD accepts the next command byte immediately.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in BUSY with wb_cyc=1. Reaching TIMEOUT without wb_ack drops wb_cyc and wb_stb and sets an error flag.
  - The next rx_stb replies ERR_BYTE instead of ACK_BYTE.
  - Reads then return 4 bytes of 8'h00 in RDAT.
  - The counter clears on entry to BUSY.
  - wb_ack in the same cycle the counter reaches TIMEOUT: the ack wins.
- Undefined: no counter; BUSY waits for wb_ack indefinitely, or until frame_rst/rst.

Test Plan:
- Write 8'h8F, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF; wb_ack 3 cycles after STB. Expect: wb_adr=8'h10, wb_sel=4'hF, wb_we=1, wb_dat_o=32'hDEADBEEF; replies 00×6 during stall, then FF; exactly one cycle issued.
- Read 8'h03, 8'h20; wb_stall high 2 cycles, wb_ack with wb_dat_i=32'h12345678. Expect: wb_stb held through the stall and dropped after acceptance; replies 00…, FF, 12, 34, 56, 78; state returns to CMD.
- wb_ack in the same cycle as rx_stb during BUSY. Expect: reply for that byte is FF, not 00.
- frame_rst after 2 write-data bytes. Expect: no WB cycle, state CMD. Then frame_rst during BUSY with wb_cyc=1: wb_cyc=0 next cycle, and a following wb_ack is ignored.
- rst asserted while wb_cyc=wb_stb=1. Expect: all outputs 0 the next cycle; a fresh command then works normally.
- With WB_TIMEOUT_EN and TIMEOUT=8, read with no wb_ack. Expect: wb_cyc drops after 8 cycles; replies EE, 00, 00, 00, 00.
